// File: rtl/pipeline_skid_stage_if.sv
// Valid/ready handshake bundle between two pipeline stages carrying an instruction and its PC.
// The master modport is the skid stage's view; the slave modport is the surrounding environment's view.
interface pipeline_skid_stage_if #(
  parameter int WIDTH    = 16,
  parameter int PC_WIDTH = 16
);
  logic                in_valid;
  logic                in_ready;
  logic [WIDTH-1:0]    in_instruction;
  logic [PC_WIDTH-1:0] in_PC;
  logic                out_valid;
  logic                out_ready;
  logic [WIDTH-1:0]    out_instruction;
  logic [PC_WIDTH-1:0] out_PC;

  modport master (
    input  in_valid, in_instruction, in_PC, out_ready,
    output in_ready, out_valid, out_instruction, out_PC
  );

  modport slave (
    output in_valid, in_instruction, in_PC, out_ready,
    input  in_ready, out_valid, out_instruction, out_PC
  );
endinterface

// File: rtl/pipeline_skid_stage.sv
// Elastic IF/ID pipeline register with a 2-entry skid buffer, flush/bubble injection
// and a saturating back-pressure counter. in_ready is decoded from the state register only.
module pipeline_skid_stage #(
  parameter int               WIDTH     = 16,
  parameter int               PC_WIDTH  = 16,
  parameter logic [WIDTH-1:0] NOP_INSTR = {WIDTH{1'b0}},
  parameter int               CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  pipeline_skid_stage_if.master bus,
  output logic [CNT_WIDTH-1:0] stall_count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t              state;
  logic [WIDTH-1:0]    main_instr;
  logic [PC_WIDTH-1:0] main_pc;
  logic [WIDTH-1:0]    skid_instr;
  logic [PC_WIDTH-1:0] skid_pc;
  logic                out_valid_int;
  logic                in_ready_int;

  assign out_valid_int       = (state != EMPTY);
  assign in_ready_int        = (state != TWO);
  assign bus.out_valid       = out_valid_int;
  assign bus.in_ready        = in_ready_int;
  assign bus.out_instruction = main_instr;
  assign bus.out_PC          = main_pc;

  // The main register is reloaded with the bubble whenever the stage drains, so the
  // outputs need no gating while empty. TWO ignores the input: the skid entry is never overtaken.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= EMPTY;
      main_instr  <= NOP_INSTR;
      main_pc     <= '0;
      skid_instr  <= '0;
      skid_pc     <= '0;
      stall_count <= '0;
    end else begin
      if (out_valid_int && !bus.out_ready && (stall_count != {CNT_WIDTH{1'b1}}))
        stall_count <= stall_count + CNT_WIDTH'(1);

      if (flush) begin
        state      <= EMPTY;
        main_instr <= NOP_INSTR;
        main_pc    <= '0;
      end else begin
        case (state)
          EMPTY: begin
            if (bus.in_valid) begin
              state      <= ONE;
              main_instr <= bus.in_instruction;
              main_pc    <= bus.in_PC;
            end
          end
          ONE: begin
            if (bus.in_valid && bus.out_ready) begin
              main_instr <= bus.in_instruction;
              main_pc    <= bus.in_PC;
            end else if (bus.in_valid) begin
              state      <= TWO;
              skid_instr <= bus.in_instruction;
              skid_pc    <= bus.in_PC;
            end else if (bus.out_ready) begin
              state      <= EMPTY;
              main_instr <= NOP_INSTR;
              main_pc    <= '0;
            end
          end
          TWO: begin
            if (bus.out_ready) begin
              state      <= ONE;
              main_instr <= skid_instr;
              main_pc    <= skid_pc;
            end
          end
          default: begin
            state      <= EMPTY;
            main_instr <= NOP_INSTR;
            main_pc    <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pipeline_skid_stage.sv
// Testbench for pipeline_skid_stage: directed vector table, reset/saturation sequences,
// and a randomized handshake run checked against a queue-based reference model.
module tb_pipeline_skid_stage;
  localparam int W  = 16;
  localparam int PW = 16;
  localparam int CW = 4;

  logic          clk   = 1'b0;
  logic          reset = 1'b1;
  logic          flush = 1'b0;
  logic [CW-1:0] stall_count;

  int vectors     = 0;
  int miscompares = 0;

  pipeline_skid_stage_if #(.WIDTH(W), .PC_WIDTH(PW)) bus ();

  pipeline_skid_stage #(
    .WIDTH    (W),
    .PC_WIDTH (PW),
    .NOP_INSTR(16'h0000),
    .CNT_WIDTH(CW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .bus        (bus),
    .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          ov;
    logic          ir;
    logic [W-1:0]  instr;
    logic [PW-1:0] pc;
    logic [CW-1:0] cnt;
  } exp_t;

  typedef struct packed {
    logic          fl;
    logic          iv;
    logic [W-1:0]  instr;
    logic [PW-1:0] pc;
    logic          ordy;
    exp_t          e;
  } vec_t;

  typedef struct packed {
    logic [W-1:0]  instr;
    logic [PW-1:0] pc;
  } entry_t;

  vec_t   vecs[18];
  entry_t mq[$];
  int     mcnt;

  function automatic exp_t mke(logic ov, logic ir, logic [W-1:0] instr, logic [PW-1:0] pc, int cnt);
    exp_t e;
    e.ov    = ov;
    e.ir    = ir;
    e.instr = instr;
    e.pc    = pc;
    e.cnt   = CW'(cnt);
    return e;
  endfunction

  function automatic vec_t mkv(logic fl, logic iv, logic [W-1:0] instr, logic [PW-1:0] pc, logic ordy, exp_t e);
    vec_t v;
    v.fl    = fl;
    v.iv    = iv;
    v.instr = instr;
    v.pc    = pc;
    v.ordy  = ordy;
    v.e     = e;
    return v;
  endfunction

  task automatic checkField(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input exp_t e);
    checkField({tag, ".out_valid"},       32'(bus.out_valid),       32'(e.ov));
    checkField({tag, ".in_ready"},        32'(bus.in_ready),        32'(e.ir));
    checkField({tag, ".out_instruction"}, 32'(bus.out_instruction), 32'(e.instr));
    checkField({tag, ".out_PC"},          32'(bus.out_PC),          32'(e.pc));
    checkField({tag, ".stall_count"},     32'(stall_count),         32'(e.cnt));
  endtask

  task automatic applyStimulus(input logic fl, input logic iv, input logic [W-1:0] instr,
                               input logic [PW-1:0] pc, input logic ordy);
    flush              = fl;
    bus.in_valid       = iv;
    bus.in_instruction = instr;
    bus.in_PC          = pc;
    bus.out_ready      = ordy;
    @(posedge clk);
    #1;
  endtask

  // Reference: a 2-deep FIFO; accepts while fewer than two words are held, pops on out_ready.
  task automatic modelStep(input logic fl, input logic iv, input logic [W-1:0] instr,
                           input logic [PW-1:0] pc, input logic ordy);
    int     sz;
    entry_t ent;
    sz = mq.size();
    if (sz > 0 && !ordy && mcnt < (1 << CW) - 1) mcnt++;
    if (fl) begin
      mq.delete();
    end else begin
      if (ordy && sz > 0) void'(mq.pop_front());
      if (iv && sz < 2) begin
        ent.instr = instr;
        ent.pc    = pc;
        mq.push_back(ent);
      end
    end
  endtask

  function automatic exp_t modelExp();
    exp_t e;
    e.ov    = (mq.size() > 0);
    e.ir    = (mq.size() < 2);
    e.instr = (mq.size() > 0) ? mq[0].instr : 16'h0000;
    e.pc    = (mq.size() > 0) ? mq[0].pc : '0;
    e.cnt   = CW'(mcnt);
    return e;
  endfunction

  initial begin
    logic          fl, iv, ordy;
    logic [W-1:0]  instr;
    logic [PW-1:0] pc;

    vecs[0]  = mkv(0, 1, 16'h1001, 16'd0,    1, mke(1, 1, 16'h1001, 16'd0,    0));
    vecs[1]  = mkv(0, 1, 16'h1002, 16'd1,    1, mke(1, 1, 16'h1002, 16'd1,    0));
    vecs[2]  = mkv(0, 1, 16'h1003, 16'd2,    1, mke(1, 1, 16'h1003, 16'd2,    0));
    vecs[3]  = mkv(0, 1, 16'h1004, 16'd3,    1, mke(1, 1, 16'h1004, 16'd3,    0));
    vecs[4]  = mkv(0, 1, 16'h1005, 16'd4,    1, mke(1, 1, 16'h1005, 16'd4,    0));
    vecs[5]  = mkv(0, 0, 16'h0000, 16'd0,    1, mke(0, 1, 16'h0000, 16'd0,    0));
    vecs[6]  = mkv(0, 1, 16'hA000, 16'h0010, 0, mke(1, 1, 16'hA000, 16'h0010, 0));
    vecs[7]  = mkv(0, 1, 16'hA001, 16'h0011, 0, mke(1, 0, 16'hA000, 16'h0010, 1));
    vecs[8]  = mkv(0, 1, 16'hA002, 16'h0012, 0, mke(1, 0, 16'hA000, 16'h0010, 2));
    vecs[9]  = mkv(0, 1, 16'hA002, 16'h0012, 1, mke(1, 1, 16'hA001, 16'h0011, 2));
    vecs[10] = mkv(0, 1, 16'hA002, 16'h0012, 1, mke(1, 1, 16'hA002, 16'h0012, 2));
    vecs[11] = mkv(0, 0, 16'h0000, 16'd0,    1, mke(0, 1, 16'h0000, 16'd0,    2));
    vecs[12] = mkv(0, 1, 16'hB000, 16'h0020, 0, mke(1, 1, 16'hB000, 16'h0020, 2));
    vecs[13] = mkv(0, 1, 16'hB001, 16'h0021, 0, mke(1, 0, 16'hB000, 16'h0020, 3));
    vecs[14] = mkv(1, 1, 16'hB002, 16'h0022, 0, mke(0, 1, 16'h0000, 16'd0,    4));
    vecs[15] = mkv(0, 0, 16'h0000, 16'd0,    1, mke(0, 1, 16'h0000, 16'd0,    4));
    vecs[16] = mkv(1, 1, 16'hC000, 16'h0030, 1, mke(0, 1, 16'h0000, 16'd0,    4));
    vecs[17] = mkv(0, 0, 16'h0000, 16'd0,    0, mke(0, 1, 16'h0000, 16'd0,    4));

    bus.in_valid       = 1'b0;
    bus.in_instruction = '0;
    bus.in_PC          = '0;
    bus.out_ready      = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset", mke(0, 1, 16'h0000, 16'd0, 0));
    reset = 1'b0;

    for (int i = 0; i < 18; i++) begin
      applyStimulus(vecs[i].fl, vecs[i].iv, vecs[i].instr, vecs[i].pc, vecs[i].ordy);
      checkOutput($sformatf("vec%0d", i), vecs[i].e);
    end

    // Fill both entries, then hit reset in the middle of the cycle.
    applyStimulus(0, 1, 16'hE000, 16'h0040, 0);
    applyStimulus(0, 1, 16'hE001, 16'h0041, 0);
    checkOutput("pre_reset_two", mke(1, 0, 16'hE000, 16'h0040, 5));
    #1;
    reset = 1'b1;
    #1;
    checkOutput("async_reset", mke(0, 1, 16'h0000, 16'd0, 0));
    @(posedge clk);
    #1;
    reset = 1'b0;
    applyStimulus(0, 1, 16'hF000, 16'h0050, 1);
    checkOutput("first_edge_accept", mke(1, 1, 16'hF000, 16'h0050, 0));

    for (int i = 0; i < 20; i++) begin
      applyStimulus(0, 0, 16'h0000, 16'd0, 0);
      checkOutput($sformatf("sat%0d", i), mke(1, 1, 16'hF000, 16'h0050, (i + 1 > 15) ? 15 : i + 1));
    end
    applyStimulus(1, 0, 16'h0000, 16'd0, 0);
    checkOutput("sat_flush", mke(0, 1, 16'h0000, 16'd0, 15));

    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    mq.delete();
    mcnt = 0;
    checkOutput("rand_reset", modelExp());

    for (int i = 0; i < 10000; i++) begin
      fl    = ($urandom_range(0, 31) == 0);
      iv    = $urandom_range(0, 1) == 1;
      ordy  = ($urandom_range(0, 9) < 6);
      instr = W'($urandom);
      pc    = PW'($urandom);
      modelStep(fl, iv, instr, pc, ordy);
      applyStimulus(fl, iv, instr, pc, ordy);
      checkOutput($sformatf("rand%0d", i), modelExp());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
